fifo_wr_packer: RTL
===================

Name: fifo_wr_packer

Overview:
- Write-side feeder for the dual-clock FIFO, running entirely in the write_clk domain.
- Accepts a narrow valid/ready stream and packs RATIO consecutive beats into one FIFO-width word, LSB lane first.
- Drives the FIFO write port (write_en/write_data) and takes backpressure from its full flag.
- in_last closes a partial word early, zero-padding the unfilled lanes.

Parameters:
- IN_WIDTH, 4, width of one input beat
- RATIO, 2, input beats per FIFO word (>=2)
- OUT_WIDTH, IN_WIDTH*RATIO, FIFO word width (derived, not overridden; default 8 matches FIFO default)
- CNT_WIDTH, 16, width of committed-word counter

Ports:
- write_clk  input  1  clock
- rst  input  1  reset
- in_valid  input  1  input beat valid
- in_ready  output  1  packer can accept beat
- in_data  input  IN_WIDTH  input beat payload
- in_last  input  1  beat ends a frame; flush current word
- fifo_write_en  output  1  to FIFO write_en
- fifo_write_data  output  OUT_WIDTH  to FIFO write_data
- fifo_full  input  1  from FIFO full
- word_count  output  CNT_WIDTH  FIFO words committed since reset (wraps)
- partial_count  output  CNT_WIDTH  committed words that were zero-padded (wraps)

Behaviour:
- Reset rst: synchronous, active-high; clock write_clk.
- While rst is high:
  - lane counter, accumulator, hold register, out_valid, word_count and partial_count all clear to 0.
  - in_ready=0 and fifo_write_en=0.
- Reset mid-operation discards any partially packed lanes and any held, uncommitted word. No write is issued for them.

Storage:
- Accumulator: OUT_WIDTH bits plus lane counter, 0..RATIO-1.
- Hold register: one OUT_WIDTH word plus out_valid flag. It is the only output buffer.

Handshake:
- Input beat accepted on in_valid && in_ready.
- in_ready = !rst && (!out_valid || !fifo_full). It is registered-state only and never depends on in_valid, in_data or in_last.
- fifo_write_en = out_valid && !fifo_full (combinational).
- fifo_write_data = hold register.
- Commit = fifo_write_en high at a write_clk edge.

Packing:
- Accepted beat writes in_data into lane [lane*IN_WIDTH +: IN_WIDTH] of the accumulator.
- Completing beat: lane==RATIO-1, or in_last=1.
  - Next cycle the hold register = accumulator with this beat merged and lanes above the current lane forced to 0.
  - out_valid=1; accumulator and lane reset to 0.
- Non-completing beat: lane increments.
- Latency: completing beat accepted in cycle N -> fifo_write_en can be high in cycle N+1 (if !fifo_full).

Simultaneous events:
- Commit and completing beat in the same cycle: hold register loads the new word, out_valid stays 1, so back-to-back words are written every cycle.
- Commit with no completing beat: out_valid clears.
- out_valid=1 and fifo_full=1: hold register stable, fifo_write_en=0, in_ready=0 (stream stalls even mid-word).
- fifo_full deasserting releases the held word in the same cycle.

Counters:
- word_count increments by 1 on each commit.
- partial_count increments on a commit whose word was closed by in_last with lane<RATIO-1.
- Both wrap modulo 2^CNT_WIDTH.

Errors/invariants:
- Never assert fifo_write_en while fifo_full=1.
- Never drop or reorder an accepted beat.

Test Plan:
- Defaults; beats 0xA,0xB (in_last=0), fifo_full=0 -> one write of 0xBA one cycle after 0xB is accepted; word_count=1, partial_count=0.
- Continuous in_valid with beats 1..8, fifo_full=0 -> writes 0x21,0x43,0x65,0x87 on alternate cycles; in_ready stays 1 throughout.
- Beat 0x5 with in_last=1 -> write 0x05; partial_count=1, lane returns to 0. A following 0x3,0x4 -> write 0x43.
- Backpressure: fifo_full=1 while word 0xBA is held; offer 0xC,0xD -> in_ready=0, fifo_write_en=0, hold stays 0xBA. Drop fifo_full -> 0xBA written that cycle, then 0xDC; no loss, no duplicate.
- Reset mid-operation: accept 0x7, assert rst one cycle, then feed 0x1,0x2 -> only write is 0x21; word_count=1.
- Counter wrap: with CNT_WIDTH=4, commit 17 words -> word_count=1.

Source files
------------

// File: rtl/fifo_wr_packer.sv
// Write-side packer for the dual-clock FIFO: gathers RATIO narrow beats into
// one FIFO word (LSB lane first) and holds it until the FIFO can take it.
module fifo_wr_packer #(
  parameter int IN_WIDTH  = 4,
  parameter int RATIO     = 2,
  parameter int CNT_WIDTH = 16,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                 write_clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 fifo_write_en,
  output logic [OUT_WIDTH-1:0] fifo_write_data,
  input  logic                 fifo_full,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] partial_count
);

  localparam int LANE_W = $clog2(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic [LANE_W-1:0]    lane;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] hold;
  logic                 out_valid;
  logic                 hold_partial;

  logic                 accept;
  logic                 complete;
  logic                 commit;
  logic [OUT_WIDTH-1:0] merged;

  assign in_ready        = !rst && (!out_valid || !fifo_full);
  assign fifo_write_en   = !rst && out_valid && !fifo_full;
  assign fifo_write_data = hold;

  assign accept   = in_valid && in_ready;
  assign complete = accept && ((lane == LAST_LANE) || in_last);
  assign commit   = fifo_write_en;

  // Lanes above the current one are always zero in acc, so a word closed
  // early by in_last comes out zero-padded without an explicit mask.
  always_comb begin
    merged = acc;
    merged[int'(lane)*IN_WIDTH +: IN_WIDTH] = in_data;
  end

  always_ff @(posedge write_clk) begin
    if (rst) begin
      lane          <= '0;
      acc           <= '0;
      hold          <= '0;
      out_valid     <= 1'b0;
      hold_partial  <= 1'b0;
      word_count    <= '0;
      partial_count <= '0;
    end else begin
      if (commit) begin
        word_count <= word_count + CNT_WIDTH'(1);
        if (hold_partial)
          partial_count <= partial_count + CNT_WIDTH'(1);
      end

      // in_ready guarantees the hold register is free or draining when complete.
      if (complete) begin
        hold         <= merged;
        hold_partial <= in_last && (lane != LAST_LANE);
        out_valid    <= 1'b1;
        acc          <= '0;
        lane         <= '0;
      end else begin
        if (commit)
          out_valid <= 1'b0;
        if (accept) begin
          acc  <= merged;
          lane <= lane + LANE_W'(1);
        end
      end
    end
  end

endmodule
